// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg -- shared definitions for the memory bus controller.
//   state_t  : controller FSM state encoding (IDLE / WAIT / DATA)
//   WS_WIDTH : width of the per-region wait-state counter
package mem_bus_pkg;

  localparam int WS_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/addr_decoder.sv
// addr_decoder -- maps the upper TAG_BITS of an address onto a slave region.
// Ports:
//   addr   in  ADDR_WIDTH  address to decode
//   hit    out 1           some region claims the address
//   region out IDX_W       index of the claiming region (lowest index wins)
module addr_decoder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_REGIONS = 4,
  parameter int TAG_BITS    = 4,
  parameter logic [NUM_REGIONS*TAG_BITS-1:0] REGION_TAG = {4'h8, 4'hF, 4'h2, 4'h0},
  parameter int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [IDX_W-1:0]      region
);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit    = 1'b0;
    region = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (addr[ADDR_WIDTH-1 -: TAG_BITS] == REGION_TAG[i*TAG_BITS +: TAG_BITS]) begin
        hit    = 1'b1;
        region = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl -- single-master memory bus controller with per-region wait states.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cpu_req/we/addr/dout         CPU access request and write data
//   cpu_din                      read data (valid in the DATA cycle only)
//   cpu_hold                     stall, high during WAIT cycles
//   s_sel/s_we                   one-hot region select / write strobe
//   s_addr/s_wdata               address and write data to slaves
//   s_rdata                      packed slave read data, region 0 in LSBs
//   bus_err                      one-cycle pulse on an unmapped access
//   err_addr/err_count           fault capture (zero unless MEM_BUS_ERR_CAPTURE_EN)
//   fsm_state                    current controller state, for observation
// Optional feature: define MEM_BUS_ERR_CAPTURE_EN to build the fault capture registers.
//
// Handshake: an access is accepted on any cycle where cpu_req=1 and the FSM is
// in IDLE or DATA; while cpu_hold=1 the CPU must keep waiting and cpu_req is
// ignored. The result is presented on cpu_din in the single DATA cycle.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_REGIONS = 4,
  parameter int TAG_BITS    = 4,
  parameter logic [NUM_REGIONS*TAG_BITS-1:0] REGION_TAG  = {4'h8, 4'hF, 4'h2, 4'h0},
  parameter logic [NUM_REGIONS*WS_WIDTH-1:0] WAIT_STATES = {4'd1, 4'd2, 4'd0, 4'd0}
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              cpu_req,
  input  logic                              cpu_we,
  input  logic [ADDR_WIDTH-1:0]             cpu_addr,
  input  logic [DATA_WIDTH-1:0]             cpu_dout,
  output logic [DATA_WIDTH-1:0]             cpu_din,
  output logic                              cpu_hold,
  output logic [NUM_REGIONS-1:0]            s_sel,
  output logic [NUM_REGIONS-1:0]            s_we,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] s_rdata,
  output logic                              bus_err,
  output logic [ADDR_WIDTH-1:0]             err_addr,
  output logic [7:0]                        err_count,
  output state_t                            fsm_state
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  state_t                state, next_state;
  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_region;
  logic [WS_WIDTH-1:0]   dec_ws;
  logic                  accept;

  logic [IDX_W-1:0]      lat_region;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  lat_we;
  logic                  lat_hit;
  logic [WS_WIDTH-1:0]   wait_cnt;

  addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGIONS(NUM_REGIONS),
    .TAG_BITS   (TAG_BITS),
    .REGION_TAG (REGION_TAG),
    .IDX_W      (IDX_W)
  ) u_addr_decoder (
    .addr  (cpu_addr),
    .hit   (dec_hit),
    .region(dec_region)
  );

  assign dec_ws    = WAIT_STATES[int'(dec_region)*WS_WIDTH +: WS_WIDTH];
  assign fsm_state = state;

  // Outputs are gated by reset_n so an asserted reset silences the bus in
  // the same cycle, even while a request is still presented.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    s_sel      = '0;
    s_we       = '0;
    s_addr     = lat_addr;
    s_wdata    = lat_wdata;
    cpu_hold   = 1'b0;
    cpu_din    = '0;
    bus_err    = 1'b0;
    if (reset_n) begin
      case (state)
        S_IDLE: accept = cpu_req;
        S_WAIT: begin
          cpu_hold = 1'b1;
          if (lat_hit) begin
            s_sel[lat_region] = 1'b1;
            s_we[lat_region]  = lat_we;
          end
          if (wait_cnt <= WS_WIDTH'(1)) next_state = S_DATA;
        end
        S_DATA: begin
          if (!lat_hit)     bus_err = 1'b1;
          else if (!lat_we) cpu_din = s_rdata[int'(lat_region)*DATA_WIDTH +: DATA_WIDTH];
          next_state = S_IDLE;
          accept     = cpu_req;   // back-to-back: DATA doubles as IDLE
        end
        default: next_state = S_IDLE;
      endcase

      if (accept) begin
        s_addr  = cpu_addr;
        s_wdata = cpu_dout;
        if (dec_hit) begin
          s_sel[dec_region] = 1'b1;
          s_we[dec_region]  = cpu_we;
          next_state = (dec_ws == '0) ? S_DATA : S_WAIT;
        end else begin
          next_state = S_DATA;    // unmapped: straight to the error cycle
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      lat_region <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      lat_hit    <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        lat_region <= dec_region;
        lat_addr   <= cpu_addr;
        lat_wdata  <= cpu_dout;
        lat_we     <= cpu_we;
        lat_hit    <= dec_hit;
        wait_cnt   <= dec_ws;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - WS_WIDTH'(1);
      end
    end
  end

`ifdef MEM_BUS_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [7:0]            err_count_q;

  // bus_err is only raised in DATA, where lat_addr still holds the faulting address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else if (bus_err) begin
      err_addr_q <= lat_addr;
      if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
`else
  assign err_addr  = '0;
  assign err_count = '0;
`endif

endmodule
